// File: rtl/decode_stage.sv
// decode_stage: register file with write-back bypass, immediate extension, ID/EX register.
// Define DECODE_LOAD_USE_STALL_EN to stall on load-use hazards against the ID/EX load.
module decode_stage #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = $clog2(REG_COUNT),
  parameter int IMM_W     = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]  imm,
  input  logic              reg_dst,
  input  logic              ext_signed,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] extended_signal,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              hazard_stall
);

  logic [DATA_W-1:0] regFile [REG_COUNT];
  logic [DATA_W-1:0] srcA;
  logic [DATA_W-1:0] srcB;
  logic [DATA_W-1:0] extImm;
  logic [ADDR_W-1:0] destSel;
  logic              accept;

  // Write-back is deliberately not gated by reset.
  always_ff @(posedge clock) begin
    if (wb_en && wb_addr != '0) begin
      regFile[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    srcA = regFile[rs];
    if (rs == '0) begin
      srcA = '0;
    end else if (wb_en && wb_addr == rs) begin
      srcA = wb_data;
    end
    srcB = regFile[rt];
    if (rt == '0) begin
      srcB = '0;
    end else if (wb_en && wb_addr == rt) begin
      srcB = wb_data;
    end
  end

  assign extImm  = {{(DATA_W-IMM_W){ext_signed & imm[IMM_W-1]}}, imm};
  assign destSel = reg_dst ? rd : rt;

`ifdef DECODE_LOAD_USE_STALL_EN
  assign hazard_stall = out_valid && mem_read_out
                     && (dest_addr != '0) && in_valid
                     && ((dest_addr == rs) || (dest_addr == rt));
`else
  assign hazard_stall = 1'b0;
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard_stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      read_data1      <= '0;
      read_data2      <= '0;
      extended_signal <= '0;
      dest_addr       <= '0;
      reg_write_out   <= 1'b0;
      mem_read_out    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      read_data1      <= srcA;
      read_data2      <= srcB;
      extended_signal <= extImm;
      dest_addr       <= destSel;
      reg_write_out   <= reg_write_in;
      mem_read_out    <= mem_read_in;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus against a cycle-level reference model.
// Honours DECODE_LOAD_USE_STALL_EN to select the expected hazard behaviour.
module tb_decode_stage;

`ifdef DECODE_LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  rs, rt, rd;
  logic [5:0]  imm;
  logic        reg_dst, ext_signed, reg_write_in, mem_read_in;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] read_data1, read_data2, extended_signal;
  logic [2:0]  dest_addr;
  logic        reg_write_out, mem_read_out, hazard_stall;

  int total = 0;
  int bad = 0;

  // reference state
  logic        mV, mRw, mMr;
  logic [2:0]  mDest;
  logic [15:0] mD1, mD2, mExt;
  logic [15:0] mRegs [8];

  decode_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .reg_dst(reg_dst), .ext_signed(ext_signed),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .read_data1(read_data1), .read_data2(read_data2),
    .extended_signal(extended_signal), .dest_addr(dest_addr),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .hazard_stall(hazard_stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mRead(input logic [2:0] a);
    if (a == 3'd0) return 16'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return mRegs[a];
  endfunction

  function automatic logic [15:0] mExtend(input logic [5:0] v, input logic sgn);
    int x;
    x = int'(v);
    if (sgn && x >= 32) x = x - 64;
    return x[15:0];
  endfunction

  function automatic logic mHazard();
    if (!STALL_EN) return 1'b0;
    return mV && mMr && mDest != 3'd0 && in_valid
        && (mDest == rs || mDest == rt);
  endfunction

  task automatic idle();
    in_valid = 0; rs = 0; rt = 0; rd = 0; imm = 0;
    reg_dst = 0; ext_signed = 0; reg_write_in = 0; mem_read_in = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic randIn();
    in_valid     = ($urandom_range(0, 3) != 0);
    rs           = 3'($urandom);
    rt           = 3'($urandom);
    rd           = 3'($urandom);
    imm          = 6'($urandom);
    reg_dst      = 1'($urandom);
    ext_signed   = 1'($urandom);
    reg_write_in = 1'($urandom);
    mem_read_in  = 1'($urandom);
    wb_en        = 1'($urandom);
    wb_addr      = 3'($urandom);
    wb_data      = 16'($urandom);
    flush        = ($urandom_range(0, 15) == 0);
    out_ready    = ($urandom_range(0, 3) != 0);
    reset_n      = ($urandom_range(0, 99) != 0);
  endtask

  // Compare at negedge, advance model across the posedge.
  task automatic tick();
    logic haz, rdy, acc;
    logic nV, nRw, nMr;
    logic [2:0] nDest;
    logic [15:0] nD1, nD2, nExt;
    logic we;
    logic [2:0] wa;
    logic [15:0] wd;
    @(negedge clock);
    haz = mHazard();
    rdy = (!mV || out_ready) && !haz;
    acc = in_valid && rdy;
    check("in_ready", in_ready, rdy);
    check("hazard_stall", hazard_stall, haz);
    check("out_valid", out_valid, mV);
    check("read_data1", read_data1, mD1);
    check("read_data2", read_data2, mD2);
    check("extended", extended_signal, mExt);
    check("dest_addr", dest_addr, mDest);
    check("reg_write_out", reg_write_out, mRw);
    check("mem_read_out", mem_read_out, mMr);
    nV = mV; nRw = mRw; nMr = mMr; nDest = mDest;
    nD1 = mD1; nD2 = mD2; nExt = mExt;
    if (!reset_n) begin
      nV = 0; nRw = 0; nMr = 0; nDest = 0; nD1 = 0; nD2 = 0; nExt = 0;
    end else if (flush) begin
      nV = 0;
    end else if (acc) begin
      nV = 1;
      nD1 = mRead(rs);
      nD2 = mRead(rt);
      nExt = mExtend(imm, ext_signed);
      nDest = reg_dst ? rd : rt;
      nRw = reg_write_in;
      nMr = mem_read_in;
    end else if (out_ready) begin
      nV = 0;
    end
    we = wb_en; wa = wb_addr; wd = wb_data;
    @(posedge clock);
    #1;
    mV = nV; mRw = nRw; mMr = nMr; mDest = nDest;
    mD1 = nD1; mD2 = nD2; mExt = nExt;
    if (we && wa != 3'd0) mRegs[wa] = wd;
  endtask

  logic [15:0] frozen;

  initial begin
    idle();
    reset_n = 0;
    mV = 0; mRw = 0; mMr = 0; mDest = 0; mD1 = 0; mD2 = 0; mExt = 0;
    for (int i = 0; i < 8; i++) mRegs[i] = 16'd0;
    @(posedge clock);
    #1;
    // reset with in_valid high; write-backs during reset still land
    for (int i = 1; i < 8; i++) begin
      in_valid = 1; rs = 3'(i); wb_en = 1;
      wb_addr = 3'(i); wb_data = 16'(i * 16'h1111);
      tick();
    end
    check("rst_out_valid", out_valid, 0);
    check("rst_read_data1", read_data1, 0);
    idle();
    reset_n = 1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // write then bypass
    in_valid = 1; rs = 3; rt = 0;
    wb_en = 1; wb_addr = 3; wb_data = 16'hBEEF;
    tick();
    check("bypass_rd1", read_data1, 16'hBEEF);
    check("bypass_rd2", read_data2, 16'h0000);
    wb_addr = 0; wb_data = 16'h1234; rs = 0; rt = 3;
    tick();
    check("reg0_bypass", read_data1, 0);
    check("reg3_stored", read_data2, 16'hBEEF);
    wb_en = 0;
    tick();
    check("reg0_after_write", read_data1, 0);

    // extension and destination
    imm = 6'b100101; ext_signed = 1;
    tick();
    check("sign_ext", extended_signal, 16'hFFE5);
    ext_signed = 0; reg_dst = 1; rd = 5; rt = 2;
    tick();
    check("zero_ext", extended_signal, 16'h0025);
    check("dest_rd", dest_addr, 5);

    // backpressure
    out_ready = 0;
    frozen = read_data2;
    for (int i = 0; i < 3; i++) begin
      rs = 3'($urandom); rt = 3'($urandom); imm = 6'($urandom);
      #1;
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_frozen", read_data2, frozen);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      rs = 3'(i + 1); rt = 3'(i);
      tick();
      check("drain_rd1", read_data1, mRegs[i + 1]);
    end

    // flush during accept
    flush = 1; rs = 7;
    tick();
    check("flush_valid", out_valid, 0);
    flush = 0;
    tick();
    check("after_flush_valid", out_valid, 1);
    check("after_flush_rd1", read_data1, 16'h7777);

    // load-use
    in_valid = 1; mem_read_in = 1; reg_dst = 1; rd = 4; rs = 1; rt = 1;
    tick();
    mem_read_in = 0; reg_dst = 0; rs = 4; rt = 2;
    #1;
    check("lu_hazard", hazard_stall, STALL_EN);
    check("lu_in_ready", in_ready, !STALL_EN);
    tick();
    check("lu_bubble", out_valid, !STALL_EN);
    tick();
    check("lu_accept_valid", out_valid, 1);
    check("lu_accept_dest", dest_addr, 2);
    check("lu_accept_rd1", read_data1, 16'h4444);

    // random
    for (int i = 0; i < 3000; i++) begin
      randIn();
      tick();
    end
    idle();
    reset_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
